// File: rtl/usb_pkt_pkg.sv
// Shared constants and FSM state encoding for the USB packetizer.
// The CSUM state exists only when USB_PKT_CHECKSUM_EN is defined.
package usb_pkt_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] EOF_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOF   = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_BYTES = 3'd4,
        ST_CNT   = 3'd5,
`ifdef USB_PKT_CHECKSUM_EN
        ST_CSUM  = 3'd6,
`endif
        ST_EOF   = 3'd7
    } state_t;

endpackage

// File: rtl/usb_byte_tx.sv
// Output holding register for the synchronous USB FIFO byte interface.
// A byte moves when wr_n and txe_n are both low; otherwise data and wr_n are held.
module usb_byte_tx (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       txe_n_i,
    output logic       byte_done_o,
    output logic [7:0] data_o,
    output logic       wr_n_o
);

    logic       wr_n_q, wr_n_d;
    logic [7:0] data_q, data_d;

    assign byte_done_o = ~wr_n_q & ~txe_n_i;
    assign data_o      = data_q;
    assign wr_n_o      = wr_n_q;

    // A load on the transfer edge keeps wr_n low for back-to-back bytes.
    always_comb begin
        wr_n_d = wr_n_q;
        data_d = data_q;
        if (load_i) begin
            wr_n_d = 1'b0;
            data_d = byte_i;
        end else if (byte_done_o) begin
            wr_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_n_q <= 1'b1;
            data_q <= '0;
        end else begin
            wr_n_q <= wr_n_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/usb_packetizer.sv
// Drains 32-bit TDC words from the capture buffer and frames them as byte packets
// (A5, payload MSB first, word count, [XOR checksum], 5A). Checksum: USB_PKT_CHECKSUM_EN.
module usb_packetizer
    import usb_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_output_ready,
    input  logic                  usb_txe_n,
    output logic                  usb_wr_n,
    output logic [7:0]            usb_data,
    output logic [15:0]           pkt_count
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic [WCW-1:0]        wcnt_inc;
    logic [15:0]           pkt_q, pkt_d;
    logic                  rd_q, rd_d;
    logic                  load;
    logic [7:0]            load_byte;
    logic                  byte_done;
    logic                  close_pkt;
`ifdef USB_PKT_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign wcnt_inc         = wcnt_q + WCW'(1);
    assign close_pkt        = (wcnt_inc == MAX_CNT) || fifo_empty;
    assign fifo_read_enable = rd_q;
    assign pkt_count        = pkt_q;

    usb_byte_tx u_byte_tx (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .byte_i      (load_byte),
        .txe_n_i     (usb_txe_n),
        .byte_done_o (byte_done),
        .data_o      (usb_data),
        .wr_n_o      (usb_wr_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_SOF;
            ST_SOF:   if (byte_done) state_d = ST_REQ;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (fifo_output_ready) state_d = ST_BYTES;
                else if (!fifo_empty)  state_d = ST_REQ;
                else                   state_d = ST_CNT;
            end
            ST_BYTES: if (byte_done && bidx_q == 2'd3) state_d = close_pkt ? ST_CNT : ST_REQ;
`ifdef USB_PKT_CHECKSUM_EN
            ST_CNT:   if (byte_done) state_d = ST_CSUM;
            ST_CSUM:  if (byte_done) state_d = ST_EOF;
`else
            ST_CNT:   if (byte_done) state_d = ST_EOF;
`endif
            ST_EOF:   if (byte_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next byte is loaded on the edge that enters (or advances within) a presenting state.
    always_comb begin
        load      = 1'b0;
        load_byte = '0;
        word_d    = word_q;
        bidx_d    = bidx_q;
        wcnt_d    = wcnt_q;
        pkt_d     = pkt_q;
        rd_d      = (state_d == ST_REQ);
`ifdef USB_PKT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    load_byte = SOF_BYTE;
                    wcnt_d    = '0;
`ifdef USB_PKT_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (fifo_output_ready) begin
                    load      = 1'b1;
                    load_byte = fifo_data[DATA_WIDTH-1 -: 8];
                    word_d    = fifo_data;
                    bidx_d    = '0;
                end else if (fifo_empty) begin
                    load      = 1'b1;
                    load_byte = 8'(wcnt_q);
                end
            end
            ST_BYTES: begin
                if (byte_done) begin
`ifdef USB_PKT_CHECKSUM_EN
                    csum_d = csum_q ^ usb_data;
`endif
                    if (bidx_q != 2'd3) begin
                        load      = 1'b1;
                        load_byte = word_q[DATA_WIDTH-9 -: 8];
                        word_d    = {word_q[DATA_WIDTH-9:0], 8'h00};
                        bidx_d    = bidx_q + 2'd1;
                    end else begin
                        wcnt_d = wcnt_inc;
                        if (close_pkt) begin
                            load      = 1'b1;
                            load_byte = 8'(wcnt_inc);
                        end
                    end
                end
            end
            ST_CNT: begin
                if (byte_done) begin
                    load      = 1'b1;
`ifdef USB_PKT_CHECKSUM_EN
                    load_byte = csum_q;
`else
                    load_byte = EOF_BYTE;
`endif
                end
            end
`ifdef USB_PKT_CHECKSUM_EN
            ST_CSUM: begin
                if (byte_done) begin
                    load      = 1'b1;
                    load_byte = EOF_BYTE;
                end
            end
`endif
            ST_EOF: begin
                if (byte_done) pkt_d = pkt_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            bidx_q <= '0;
            wcnt_q <= '0;
            pkt_q  <= '0;
            rd_q   <= 1'b0;
`ifdef USB_PKT_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            word_q <= word_d;
            bidx_q <= bidx_d;
            wcnt_q <= wcnt_d;
            pkt_q  <= pkt_d;
            rd_q   <= rd_d;
`ifdef USB_PKT_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_packetizer.sv
// Directed bench for usb_packetizer with a behavioural capture-buffer model.
// Expected streams follow USB_PKT_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_usb_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_read_enable;
    logic [31:0] fifo_data = '0;
    logic        fifo_output_ready = 1'b0;
    logic        usb_txe_n = 1'b0;
    logic        usb_wr_n;
    logic [7:0]  usb_data;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    usb_packetizer #(.DATA_WIDTH(32), .MAX_WORDS(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_empty        (fifo_empty),
        .fifo_read_enable  (fifo_read_enable),
        .fifo_data         (fifo_data),
        .fifo_output_ready (fifo_output_ready),
        .usb_txe_n         (usb_txe_n),
        .usb_wr_n          (usb_wr_n),
        .usb_data          (usb_data),
        .pkt_count         (pkt_count)
    );

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [31:0] bufq[$];
    logic [7:0]  cap_q[$];
    int unsigned cap_t[$];
    logic [7:0]  exp_q[$];
    logic [31:0] words[$];
    int          rd_pulses = 0;
    int          adj_err = 0;
    int          preempt = 0;
    logic        drain = 1'b0;
    logic        prev_rd = 1'b0;
    logic        rd_pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer model: answers a sampled read one edge later, unless pre-empted or drained.
    always @(posedge clk) begin
        cyc++;
        #1;
        fifo_output_ready = 1'b0;
        if (rd_pending) begin
            rd_pending = 1'b0;
            if (drain) begin
                bufq.delete();
                drain = 1'b0;
            end else if (preempt > 0) begin
                preempt--;
            end else if (bufq.size() > 0) begin
                fifo_data = bufq.pop_front();
                fifo_output_ready = 1'b1;
            end
        end
        fifo_empty = (bufq.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!usb_wr_n && !usb_txe_n) begin
                cap_q.push_back(usb_data);
                cap_t.push_back(cyc);
            end
            if (fifo_read_enable) begin
                rd_pulses++;
                if (prev_rd) adj_err++;
                rd_pending = 1'b1;
            end
        end
        prev_rd = fifo_read_enable;
    end

    task automatic clear_capture();
        cap_q.delete();
        cap_t.delete();
        rd_pulses = 0;
        adj_err = 0;
    endtask

    task automatic wait_pkts(input string tag, input logic [15:0] target);
        int unsigned n = 0;
        while (pkt_count !== target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_pkt_count"}, pkt_count, target);
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] e[$]);
        logic [7:0] g;
        chk({tag, "_len"}, cap_q.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            g = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), g, e[i]);
        end
    endtask

    task automatic build_exp(input logic [31:0] w[$], output logic [7:0] e[$]);
        int          idx;
        int          n;
        logic [7:0]  cs;
        logic [7:0]  bt;
        logic [31:0] tmp;
        e.delete();
        idx = 0;
        while (idx < w.size()) begin
            e.push_back(8'hA5);
            n = 0;
            cs = '0;
            while (n < 16 && idx < w.size()) begin
                tmp = w[idx];
                for (int b = 0; b < 4; b++) begin
                    bt = tmp[31 - 8*b -: 8];
                    e.push_back(bt);
                    cs ^= bt;
                end
                n++;
                idx++;
            end
            e.push_back(8'(n));
`ifdef USB_PKT_CHECKSUM_EN
            e.push_back(cs);
`endif
            e.push_back(8'h5A);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd_en", fifo_read_enable, 1'b0);
        chk("rst_wr_n", usb_wr_n, 1'b1);
        chk("rst_data", usb_data, 8'h00);
        chk("rst_pkt_count", pkt_count, 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word, back-to-back bytes, packet duration.
        clear_capture();
        bufq.push_back(32'h12345678);
        wait_pkts("one", 16'd1);
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'h08);
        chk("one_duration", cap_t[cap_t.size()-1] - cap_t[0], 32'd9);
`else
        chk("one_duration", cap_t[cap_t.size()-1] - cap_t[0], 32'd8);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("one", exp_q);
        chk("one_reads", rd_pulses, 32'd1);

        clear_capture();
        bufq.push_back(32'hDEADBEEF);
        wait_pkts("dead", 16'd2);
        exp_q = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'h22);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("dead", exp_q);

        // 20 words split by MAX_WORDS into 16 + 4.
        clear_capture();
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(32'h01234567 + 32'h11111111 * i);
        foreach (words[i]) bufq.push_back(words[i]);
        wait_pkts("twenty", 16'd4);
        build_exp(words, exp_q);
        chk_stream("twenty", exp_q);
        chk("twenty_cnt1", cap_q[65], 8'h10);
        chk("twenty_reads", rd_pulses, 32'd20);
        chk("twenty_adjacent", adj_err, 32'd0);

        // Backpressure during byte 0x56.
        clear_capture();
        bufq.push_back(32'h12345678);
        begin
            int unsigned n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!(usb_data == 8'h56 && !usb_wr_n) && n < 200);
            chk("bp_found56", usb_data, 8'h56);
            usb_txe_n = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("bp_hold_data%0d", k), usb_data, 8'h56);
                chk($sformatf("bp_hold_wr%0d", k), usb_wr_n, 1'b0);
            end
            usb_txe_n = 1'b0;
        end
        wait_pkts("bp", 16'd5);
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'h08);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("bp", exp_q);

        // First read pre-empted while the buffer stays non-empty.
        clear_capture();
        preempt = 1;
        bufq.push_back(32'hCAFEF00D);
        wait_pkts("pre", 16'd6);
        exp_q = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'hC9);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("pre", exp_q);
        chk("pre_reads", rd_pulses, 32'd2);
        chk("pre_adjacent", adj_err, 32'd0);

        // Buffer empties under the only read: zero-word packet.
        clear_capture();
        drain = 1'b1;
        bufq.push_back(32'h99999999);
        wait_pkts("zero", 16'd7);
        exp_q = '{8'hA5, 8'h00};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'h00);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("zero", exp_q);
        chk("zero_reads", rd_pulses, 32'd1);

        // Reset in the middle of the payload.
        clear_capture();
        bufq.push_back(32'h11223344);
        begin
            int unsigned n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!(usb_data == 8'h22 && !usb_wr_n) && n < 200);
            chk("mid_found22", usb_data, 8'h22);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("mid_rst_wr_n", usb_wr_n, 1'b1);
            chk("mid_rst_data", usb_data, 8'h00);
            chk("mid_rst_rd_en", fifo_read_enable, 1'b0);
            chk("mid_rst_pkt_count", pkt_count, 16'd0);
            rst = 1'b0;
        end
        repeat (2) @(negedge clk);
        clear_capture();
        bufq.push_back(32'h55667788);
        wait_pkts("after", 16'd1);
        exp_q = '{8'hA5, 8'h55, 8'h66, 8'h77, 8'h88, 8'h01};
`ifdef USB_PKT_CHECKSUM_EN
        exp_q.push_back(8'hCC);
`endif
        exp_q.push_back(8'h5A);
        chk_stream("after", exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_packetizer.md
# usb_packetizer

Downstream consumer of the HPTDC capture buffer: drains 32-bit TDC words from the buffer's read port and streams them as framed byte packets to the FT232H-style synchronous USB FIFO. Each packet carries a start byte, up to `MAX_WORDS` words (4 bytes each, MSB first), a word-count trailer, an optional XOR checksum and an end byte. A packet is closed when `MAX_WORDS` is reached or the buffer runs empty.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of a buffer word; fixed at 4 bytes.
- `MAX_WORDS`, 16, maximum words per packet; legal range 1..255.

Ports:
- `clk`  input  1  single system clock; every register is on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `fifo_empty`  input  1  buffer empty flag.
- `fifo_read_enable`  output  1  one-cycle read request to the buffer.
- `fifo_data`  input  DATA_WIDTH  buffer data_out; valid while `fifo_output_ready`=1.
- `fifo_output_ready`  input  1  one-cycle pulse, registered by the buffer on the edge that sampled the read.
- `usb_txe_n`  input  1  USB FIFO has space when 0.
- `usb_wr_n`  output  1  byte valid when 0.
- `usb_data`  output  8  byte to USB FIFO.
- `pkt_count`  output  16  number of completed packets (EOF byte transferred); wraps at 0xFFFF→0.

## Operation
- Byte transfer rule: a byte moves on a rising edge where `usb_wr_n`=0 and `usb_txe_n`=0. While `usb_txe_n`=1, `usb_data` and `usb_wr_n` are held unchanged. Between bytes that are not back-to-back, `usb_wr_n`=1.
- States: IDLE, SOF, REQ, WAIT, BYTES, CNT, CSUM, EOF.
- IDLE: `fifo_empty`=0 → SOF; clear word counter and checksum.
- SOF: present 0xA5; on transfer → REQ.
- REQ: drive `fifo_read_enable`=1 for exactly one cycle → WAIT.
- WAIT (one cycle): `fifo_output_ready`=1 → latch `fifo_data` into shift register, → BYTES. Otherwise (read pre-empted by a buffer write): `fifo_empty`=0 → REQ (retry); `fifo_empty`=1 → CNT.
- BYTES: present bytes [31:24], [23:16], [15:8], [7:0] in order, advancing only on transfer; each transferred payload byte XORed into checksum. After 4th transfer increment word counter; counter = `MAX_WORDS` or `fifo_empty`=1 → CNT, else → REQ.
- CNT: present word counter (8 bits); on transfer → CSUM if enabled, else EOF.
- CSUM: present checksum; on transfer → EOF.
- EOF: present 0x5A; on transfer increment `pkt_count` → IDLE.
- Word counter width is $clog2(MAX_WORDS+1), zero-extended to 8 bits in CNT. A zero-word packet (A5 00 [00] 5A) is legal and produced only if every read attempt after SOF found the buffer empty.
- `fifo_read_enable` is never high on two consecutive cycles and never high outside REQ.

## Timing
- Reset values: `fifo_read_enable`=0, `usb_wr_n`=1, `usb_data`=0x00, `pkt_count`=0, state IDLE. `rst` mid-packet abandons the packet immediately; no EOF is emitted.
- With `usb_txe_n` held 0: IDLE→first SOF byte presented 1 cycle after `fifo_empty` falls; per word 2 cycles (REQ, WAIT) + 4 byte cycles; packet of N words = 1 + 6N + 2 (+1 with checksum) cycles from SOF presentation.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `USB_PKT_CHECKSUM_EN` defined: CSUM state present; checksum byte (XOR of all payload bytes, excluding SOF/count/EOF) sent between count and EOF.
- Not defined: CSUM state and checksum register absent; CNT goes directly to EOF.

## Structure
- Package `usb_pkt_pkg`: SOF constant 8'hA5, EOF constant 8'h5A, state encoding constants.
- One sub-module, `usb_byte_tx`: holding register for `usb_data`/`usb_wr_n` implementing the transfer/hold rule; accepts a load strobe and returns a `byte_done` pulse to the FSM.

## Test plan
- Single word 0x12345678, `usb_txe_n`=0, checksum on → bytes A5 12 34 56 78 01 08 5A; `pkt_count`=1.
- 20 words buffered, `MAX_WORDS`=16 → two packets, count bytes 0x10 then 0x04; `pkt_count`=2; exactly 20 read pulses.
- Backpressure: `usb_txe_n`=1 for 5 cycles during byte 0x56 → `usb_data` held 0x56, `usb_wr_n` held 0; no byte lost or duplicated.
- Pre-empted read: `fifo_output_ready` withheld after REQ with `fifo_empty`=0 → second `fifo_read_enable` pulse, payload still correct, never two adjacent read cycles.
- Checksum off build, word 0xDEADBEEF → A5 DE AD BE EF 01 5A.
- `rst` asserted mid-BYTES → next cycle `usb_wr_n`=1, `usb_data`=0, `fifo_read_enable`=0, `pkt_count`=0; next packet starts cleanly with A5.
